// File: rtl/conv_out_fifo_if.sv
// Handshake bundle between a producing conv stage, conv_out_fifo and the consuming line buffer.
// master = the stage side that drives beats and read requests, slave = the FIFO itself.
interface conv_out_fifo_if #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 512
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  fifo_almost_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output i_data, i_valid, fifo_rd_en,
        input  o_data, o_valid, fifo_almost_full, fifo_empty, fifo_count, overflow, underflow
    );

    modport slave (
        input  i_data, i_valid, fifo_rd_en,
        output o_data, o_valid, fifo_almost_full, fifo_empty, fifo_count, overflow, underflow
    );
endinterface

// File: rtl/conv_out_fifo.sv
// Inter-layer buffer between two conv stages: captures every producer beat, registered read with
// one-cycle latency, early almost-full so the producer's in-flight PE results still fit.
module conv_out_fifo #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 512,
    parameter int AF_GAP     = 32
) (
    input  logic           clk,
    input  logic           rst,
    conv_out_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_GAP);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("conv_out_fifo: DEPTH must be a power of two and >= 4");
    end
    if ((AF_GAP < 1) || (AF_GAP >= DEPTH)) begin : g_bad_af_gap
        $error("conv_out_fifo: AF_GAP must satisfy 1 <= AF_GAP < DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  rd_acc;
    logic                  wr_acc;

    logic [DATA_WIDTH-1:0] o_data_q;
    logic                  o_valid_q;
    logic                  empty_q;
    logic                  almost_full_q;
    logic                  overflow_q;
    logic                  underflow_q;

    // A read needs stored data; a write into a full FIFO only fits when a read frees a slot
    // in the same cycle. There is no write-through path, so an empty FIFO refuses the read.
    // NOTE: every signal driven in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        rd_acc    = bus.fifo_rd_en && (count != '0);
        wr_acc    = bus.i_valid && ((count != FULL_LEVEL) || rd_acc);
        count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; the pointers and count
    // make stale contents unreachable after reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end

    // Flags are computed from count_nxt so they line up with fifo_count in the same cycle.
    // NOTE: sequential state is updated with non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_data_q      <= '0;
            o_valid_q     <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + 1'b1;
                o_data_q <= mem[rd_ptr];
            end
            o_valid_q     <= rd_acc;
            count         <= count_nxt;
            empty_q       <= (count_nxt == '0);
            almost_full_q <= (count_nxt >= AF_LEVEL);
            if (bus.i_valid && !wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (bus.fifo_rd_en && !rd_acc) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.o_data           = o_data_q;
    assign bus.o_valid          = o_valid_q;
    assign bus.fifo_empty       = empty_q;
    assign bus.fifo_almost_full = almost_full_q;
    assign bus.fifo_count       = count;
    assign bus.overflow         = overflow_q;
    assign bus.underflow        = underflow_q;

    a_count_range: assert property (@(posedge clk) disable iff (rst) count <= FULL_LEVEL);
    a_empty_track: assert property (@(posedge clk) disable iff (rst) empty_q == (count == '0));
    a_ptr_gap:     assert property (@(posedge clk) disable iff (rst)
                                    AW'(wr_ptr - rd_ptr) == AW'(count));
endmodule

// File: tb/tb_conv_out_fifo.sv
// Scoreboard bench for conv_out_fifo: directed scenarios plus a long randomized phase, all checked
// against a queue-based reference model of FIFO occupancy and flag rules.
module tb_conv_out_fifo;
    localparam int DW     = 256;
    localparam int DEPTH  = 512;
    localparam int AF_GAP = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_out_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    conv_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_GAP(AF_GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: stored beats, beats already read and awaiting output, sticky flags.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_ov   = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          model_of = 1'b0;
    logic          model_uf = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        exp_ov    = 1'b0;
        hold_data = '0;
        model_of  = 1'b0;
        model_uf  = 1'b0;
    endtask

    // Applies the FIFO rules for one clock edge to the model.
    task automatic model_update(input logic v, input logic [DW-1:0] d, input logic r);
        bit had_data = (model_q.size() != 0);
        bit was_full = (model_q.size() == DEPTH);
        exp_ov = 1'b0;
        if (r && had_data) begin
            exp_q.push_back(model_q.pop_front());
            exp_ov = 1'b1;
        end
        if (r && !had_data) model_uf = 1'b1;
        if (v) begin
            if (!was_full || (r && had_data)) model_q.push_back(d);
            else model_of = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        bus.i_valid    = v;
        bus.i_data     = d;
        bus.fifo_rd_en = r;
        @(posedge clk);
        model_update(v, d, r);
        @(negedge clk);
        bus.i_valid    = 1'b0;
        bus.fifo_rd_en = 1'b0;
    endtask

    // Asserts reset partway through the low clock phase and checks outputs before the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_o_valid", DW'(bus.o_valid), '0);
        check("rst_o_data", bus.o_data, '0);
        check("rst_count", DW'(bus.fifo_count), '0);
        check("rst_empty", DW'(bus.fifo_empty), DW'(1));
        check("rst_af", DW'(bus.fifo_almost_full), '0);
        check("rst_overflow", DW'(bus.overflow), '0);
        check("rst_underflow", DW'(bus.underflow), '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every registered output against the model once per cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("o_valid", DW'(bus.o_valid), DW'(exp_ov));
            if (exp_ov && !rst) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underrun", '0, DW'(1));
                end else begin
                    hold_data = exp_q.pop_front();
                end
            end
            check("o_data", bus.o_data, hold_data);
            check("count", DW'(bus.fifo_count), DW'(model_q.size()));
            check("empty", DW'(bus.fifo_empty), DW'(model_q.size() == 0));
            check("almost_full", DW'(bus.fifo_almost_full), DW'(model_q.size() >= DEPTH - AF_GAP));
            check("overflow", DW'(bus.overflow), DW'(model_of));
            check("underflow", DW'(bus.underflow), DW'(model_uf));
        end
    end

    initial begin
        logic [DW-1:0] beat;
        bus.i_valid    = 1'b0;
        bus.i_data     = '0;
        bus.fifo_rd_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-stream, with a read result on o_valid at the moment reset arrives.
        for (int i = 0; i < 5; i++) step(1'b1, rand_beat(), 1'b0);
        step(1'b0, '0, 1'b1);
        check("pre_rst_o_valid", DW'(bus.o_valid), DW'(1));
        do_reset();

        // Three beats then three reads.
        step(1'b1, DW'(32'hA), 1'b0);
        step(1'b1, DW'(32'hB), 1'b0);
        step(1'b1, DW'(32'hC), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("abc_last_data", bus.o_data, DW'(32'hC));
        check("abc_empty", DW'(bus.fifo_empty), DW'(1));

        // Fill to DEPTH, drop one extra beat, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, DW'(32'hDEAD), 1'b0);
        check("fill_overflow", DW'(bus.overflow), DW'(1));
        check("fill_count", DW'(bus.fifo_count), DW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        do_reset();

        // Full with simultaneous read and write: marker beat must come out last.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i + 1000), 1'b0);
        step(1'b1, DW'(32'hBEEF), 1'b1);
        check("full_rw_overflow", DW'(bus.overflow), '0);
        check("full_rw_count", DW'(bus.fifo_count), DW'(DEPTH));
        check("full_rw_oldest", bus.o_data, DW'(1000));
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("full_rw_marker_last", bus.o_data, DW'(32'hBEEF));
        do_reset();

        // Read while empty with a write in the same cycle: no write-through.
        step(1'b1, DW'(32'h5A5A), 1'b1);
        check("empty_rw_o_valid", DW'(bus.o_valid), '0);
        check("empty_rw_underflow", DW'(bus.underflow), DW'(1));
        check("empty_rw_count", DW'(bus.fifo_count), DW'(1));
        do_reset();

        // Randomized traffic in phases biased toward filling, draining and balance.
        for (int ph = 0; ph < 10; ph++) begin
            int wr_pct = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
            int rd_pct = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 85 : 50;
            for (int i = 0; i < 1000; i++) begin
                beat = rand_beat();
                step($urandom_range(99) < wr_pct, beat, $urandom_range(99) < rd_pct);
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("final_scoreboard_empty", DW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
